// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the multi-cycle execute stage
package ex_pkg;
  localparam int CTRL_W_DEF = 8;
  localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10, ALUOP_AND = 2'b11;
  localparam logic [5:0] FUNCT_ADD = 6'h20, FUNCT_SUB = 6'h22, FUNCT_AND = 6'h24, FUNCT_OR = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2a, FUNCT_SLTU = 6'h2b, FUNCT_MULT = 6'h18;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_MUL, ALU_ILL} alu_ctl_e;
  typedef enum logic [1:0] {IDLE, MUL, WB} state_e;
  function automatic alu_ctl_e funct_ctl(input logic [5:0] f);
    return f == FUNCT_ADD ? ALU_ADD : f == FUNCT_SUB ? ALU_SUB : f == FUNCT_AND ? ALU_AND :
           f == FUNCT_OR ? ALU_OR : f == FUNCT_SLT ? ALU_SLT : f == FUNCT_SLTU ? ALU_SLTU :
           f == FUNCT_MULT ? ALU_MUL : ALU_ILL;
  endfunction
endpackage

// File: rtl/ex_iter_mul.sv
// ex_iter_mul: shift-add multiplier retiring MUL_BPC multiplier bits per edge, low XLEN product bits
module ex_iter_mul #(
  parameter int XLEN = 32,
  parameter int MUL_BPC = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int STEPS = XLEN / MUL_BPC;
  localparam int CW = $clog2(STEPS + 1);
  logic [XLEN-1:0] a_d, a_q, b_d, b_q, acc_d, acc_q, src_a, src_b, partial;
  logic [CW-1:0] cnt_d, cnt_q;
  logic busy_d, busy_q;
  // the start edge already retires the first chunk, so the last one lands XLEN/MUL_BPC-1 edges later
  always_comb begin
    src_a = start ? a : a_q;
    src_b = start ? b : b_q;
    partial = '0;
    for (int i = 0; i < MUL_BPC; i++) partial = partial + (src_b[i] ? src_a << i : '0);
    done = busy_q && cnt_q <= CW'(1);
    busy_d = abort ? 1'b0 : start ? 1'b1 : busy_q && !done;
    cnt_d = start ? CW'(STEPS - 1) : busy_q ? cnt_q - 1'b1 : cnt_q;
    acc_d = start ? partial : busy_q ? acc_q + partial : acc_q;
    a_d = src_a << MUL_BPC;
    b_d = src_b >> MUL_BPC;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  assign busy = busy_q;
  assign product = acc_q;
endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with combinational ALU, iterative multiplier and a valid/ready EX/MEM register
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int MUL_BPC = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_rs_val,
  input  logic [XLEN-1:0]    in_rt_val,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_alu_src,
  input  logic               in_reg_dst,
  input  logic [1:0]         in_alu_op,
  input  logic [RADDR_W-1:0] in_rt,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]    in_next_pc,
  input  logic [XLEN-1:0]    in_pc_jump,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic               out_zero,
  output logic [RADDR_W-1:0] out_wreg,
  output logic [XLEN-1:0]    out_wdata,
  output logic [XLEN-1:0]    out_br_pc,
  output logic [XLEN-1:0]    out_pc_jump,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic               out_illegal
);
  localparam int SIDE_W = RADDR_W + 3 * XLEN + CTRL_W;
  localparam int OUT_W = XLEN + 2 + SIDE_W;
  alu_ctl_e ctl;
  state_e state_d, state_q;
  logic [XLEN-1:0] op_b, alu_res, product;
  logic [SIDE_W-1:0] side_in, side_d, side_q;
  logic [OUT_W-1:0] out_d, out_q;
  logic out_valid_d, out_valid_q, drain_ok, accept, load_alu, load_mul, mul_start, mul_busy, mul_done, zero;
  always_comb begin
    op_b = in_alu_src ? in_imm : in_rt_val;
    ctl = in_alu_op == ALUOP_ADD ? ALU_ADD : in_alu_op == ALUOP_SUB ? ALU_SUB :
          in_alu_op == ALUOP_AND ? ALU_AND : funct_ctl(in_imm[5:0]);
    alu_res = ctl == ALU_ADD ? in_rs_val + op_b : ctl == ALU_SUB ? in_rs_val - op_b :
              ctl == ALU_AND ? in_rs_val & op_b : ctl == ALU_OR ? in_rs_val | op_b :
              ctl == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(in_rs_val) < $signed(op_b)} :
              ctl == ALU_SLTU ? {{(XLEN-1){1'b0}}, in_rs_val < op_b} : '0;
    zero = alu_res == '0 && in_alu_op == ALUOP_SUB;
    side_in = {in_reg_dst ? in_rd : in_rt, in_rt_val, in_next_pc + (in_imm << 2), in_pc_jump, in_ctrl};
    drain_ok = !out_valid_q || out_ready;
    in_ready = reset_n && state_q == IDLE && !mul_busy && drain_ok && !flush;
    accept = in_valid && in_ready;
    load_alu = accept && ctl != ALU_MUL;
    mul_start = accept && ctl == ALU_MUL;
    load_mul = state_q == WB && drain_ok && !flush;
    // a multiply reports no zero flag and is never illegal
    out_d = load_alu ? {alu_res, zero, ctl == ALU_ILL, side_in} : load_mul ? {product, 2'b00, side_q} : out_q;
    out_valid_d = !flush && (load_alu || load_mul || (out_valid_q && !out_ready));
    side_d = mul_start ? side_in : side_q;
    state_d = flush ? IDLE : state_q == IDLE ? (mul_start ? MUL : IDLE) :
              state_q == MUL ? (mul_done ? WB : MUL) : (load_mul ? IDLE : WB);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      out_q <= '0;
      side_q <= '0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      out_q <= out_d;
      side_q <= side_d;
    end
  end
  ex_iter_mul #(.XLEN(XLEN), .MUL_BPC(MUL_BPC)) u_mul (
    .clock(clock), .reset_n(reset_n), .start(mul_start), .abort(flush),
    .a(in_rs_val), .b(op_b), .busy(mul_busy), .done(mul_done), .product(product)
  );
  assign out_valid = out_valid_q;
  assign {out_result, out_zero, out_illegal, out_wreg, out_wdata, out_br_pc, out_pc_jump, out_ctrl} = out_q;
endmodule
